// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array controller.
// Holds the FSM state encoding and the index/counter widths.
// Counter is one bit wider than an index so K+2N-3 never wraps.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int IDX_W = 8;
    localparam int CNT_W = 9;

endpackage

// File: rtl/sa_skew_gen.sv
// Skewed operand feed: cycle counter t plus per-lane valid/index decode.
// Latency: valids/indices decode from registered t and run, no input-to-output path.
// No backpressure; the counter advances every cycle while run is high.
module sa_skew_gen
    import sa_ctrl_pkg::*;
#(
    parameter int N = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [IDX_W-1:0]   k,
    output logic [N-1:0]       vld,
    output logic [N*IDX_W-1:0] addr,
    output logic               last
);

    logic [CNT_W-1:0] t;
    logic [CNT_W-1:0] t_end;

    // Final feed cycle is t = K+2N-3; modular arithmetic keeps N=1 correct.
    assign t_end = {1'b0, k} + CNT_W'(2 * N - 3);

    // Counter restarts from zero whenever the feed phase is not running.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            t <= '0;
        end else begin
            t <= t + CNT_W'(1);
        end
    end

    // Lane i is skewed by i cycles: valid while 0 <= t-i < K, index t-i.
    always_comb begin
        vld  = '0;
        addr = '0;
        for (int i = 0; i < N; i++) begin
            if (run && (t >= CNT_W'(i)) && ((t - CNT_W'(i)) < {1'b0, k})) begin
                vld[i]                    = 1'b1;
                addr[i*IDX_W +: IDX_W]    = t[IDX_W-1:0] - IDX_W'(i);
            end
        end
    end

    assign last = run && (t == t_end);

endmodule

// File: rtl/sa_ctrl.sv
// Systolic-array pass sequencer: clear, skewed feed, drain, done pulse.
// Latency: start accepted -> clear next cycle; done K+2N-2+PE_LAT+2 cycles after start.
// No backpressure; start is ignored outside IDLE, abort drops the pass to IDLE.
module sa_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int N      = 2,
    parameter int PE_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         k_len,
    input  logic               abort,
    output logic               clear,
    output logic               en,
    output logic [N*IDX_W-1:0] a_addr,
    output logic [N-1:0]       a_vld,
    output logic [N*IDX_W-1:0] b_addr,
    output logic [N-1:0]       b_vld,
    output logic               busy,
    output logic               done
);

    state_t           state;
    logic [IDX_W-1:0] k_q;
    logic [15:0]      drn_cnt;
    logic             abort_clr;
    logic             feed_run;
    logic             a_last;
    logic             b_last;

    assign feed_run = (state == ST_FEED);

    // Pass sequencing; abort from an active state leaves one clear cycle behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_q       <= '0;
            drn_cnt   <= '0;
            abort_clr <= 1'b0;
        end else begin
            abort_clr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_q   <= k_len;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        abort_clr <= 1'b1;
                    end else if (k_q == '0) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        abort_clr <= 1'b1;
                    end else if (a_last && b_last) begin
                        drn_cnt <= '0;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        abort_clr <= 1'b1;
                    end else if (drn_cnt == 16'(PE_LAT - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        drn_cnt <= drn_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Control strobes are decoded from registered state only.
    assign clear = (state == ST_CLEAR) || abort_clr;
    assign en    = (state == ST_FEED) || (state == ST_DRAIN);
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);

    sa_skew_gen #(.N(N)) u_skew_a (
        .clk  (clk),
        .rst  (rst),
        .run  (feed_run),
        .k    (k_q),
        .vld  (a_vld),
        .addr (a_addr),
        .last (a_last)
    );

    sa_skew_gen #(.N(N)) u_skew_b (
        .clk  (clk),
        .rst  (rst),
        .run  (feed_run),
        .k    (k_q),
        .vld  (b_vld),
        .addr (b_addr),
        .last (b_last)
    );

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl with N=2, PE_LAT=1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived per cycle.
module tb_sa_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic        abort;
    logic        clear;
    logic        en;
    logic [15:0] a_addr;
    logic [1:0]  a_vld;
    logic [15:0] b_addr;
    logic [1:0]  b_vld;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    // Cycle-by-cycle expectations for a K=3 pass, starting at the CLEAR cycle.
    // ctl = {busy, done, clear, en}
    logic [3:0]  k3_ctl  [0:8] = '{4'b1010, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                                   4'b1001, 4'b1001, 4'b1100, 4'b0000};
    logic [1:0]  k3_vld  [0:8] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10,
                                   2'b00, 2'b00, 2'b00, 2'b00};
    logic [15:0] k3_addr [0:8] = '{16'h0000, 16'h0000, 16'h0001, 16'h0102, 16'h0200,
                                   16'h0000, 16'h0000, 16'h0000, 16'h0000};

    sa_ctrl #(.N(2), .PE_LAT(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .k_len  (k_len),
        .abort  (abort),
        .clear  (clear),
        .en     (en),
        .a_addr (a_addr),
        .a_vld  (a_vld),
        .b_addr (b_addr),
        .b_vld  (b_vld),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [3:0] ctl,
                           input logic [1:0] vld, input logic [15:0] ad);
        chk({tag, "_ctl"},   {28'd0, busy, done, clear, en}, {28'd0, ctl});
        chk({tag, "_avld"},  {30'd0, a_vld}, {30'd0, vld});
        chk({tag, "_bvld"},  {30'd0, b_vld}, {30'd0, vld});
        chk({tag, "_aaddr"}, {16'd0, a_addr}, {16'd0, ad});
        chk({tag, "_baddr"}, {16'd0, b_addr}, {16'd0, ad});
    endtask

    // Full K=3 pass: start in the current cycle, then check CLEAR..IDLE.
    task automatic run_k3(input string tag);
        start = 1'b1;
        k_len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_cyc($sformatf("%s_c%0d", tag, i + 1), k3_ctl[i], k3_vld[i], k3_addr[i]);
            step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b1;
        abort  = 1'b1;
        k_len  = 8'd5;

        // Reset wins over start and abort.
        step();
        step();
        chk_cyc("reset", 4'b0000, 2'b00, 16'h0000);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        step();
        chk_cyc("idle", 4'b0000, 2'b00, 16'h0000);

        // Nominal K=3 pass.
        run_k3("k3");

        // K=0 goes CLEAR -> DONE with no enable.
        start = 1'b1;
        k_len = 8'd0;
        step();
        start = 1'b0;
        chk_cyc("k0_clear", 4'b1010, 2'b00, 16'h0000);
        step();
        chk_cyc("k0_done", 4'b1100, 2'b00, 16'h0000);
        step();
        chk_cyc("k0_idle", 4'b0000, 2'b00, 16'h0000);

        // Abort on the third FEED cycle.
        start = 1'b1;
        k_len = 8'd3;
        step();
        start = 1'b0;
        chk_cyc("ab_clear", 4'b1010, 2'b00, 16'h0000);
        step();
        chk_cyc("ab_f0", 4'b1001, 2'b01, 16'h0000);
        step();
        chk_cyc("ab_f1", 4'b1001, 2'b11, 16'h0001);
        step();
        abort = 1'b1;
        chk_cyc("ab_f2", 4'b1001, 2'b11, 16'h0102);
        step();
        abort = 1'b0;
        chk_cyc("ab_idle_clr", 4'b0010, 2'b00, 16'h0000);
        step();
        chk_cyc("ab_idle", 4'b0000, 2'b00, 16'h0000);
        step();
        chk_cyc("ab_idle2", 4'b0000, 2'b00, 16'h0000);
        run_k3("post_ab");

        // Start beats abort in IDLE; abort in DONE and IDLE has no effect.
        start = 1'b1;
        abort = 1'b1;
        k_len = 8'd0;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk_cyc("sa_clear", 4'b1010, 2'b00, 16'h0000);
        step();
        abort = 1'b1;
        chk_cyc("sa_done", 4'b1100, 2'b00, 16'h0000);
        step();
        chk_cyc("sa_idle", 4'b0000, 2'b00, 16'h0000);
        step();
        abort = 1'b0;
        chk_cyc("sa_idle2", 4'b0000, 2'b00, 16'h0000);

        // Reset during DRAIN drops the pass.
        start = 1'b1;
        k_len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk_cyc("rd_drain", 4'b1001, 2'b00, 16'h0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cyc("rd_reset", 4'b0000, 2'b00, 16'h0000);
        step();
        chk_cyc("rd_idle", 4'b0000, 2'b00, 16'h0000);

        // Start held through a K=0 pass is only re-accepted in IDLE.
        start = 1'b1;
        k_len = 8'd0;
        step();
        chk_cyc("hold_clear", 4'b1010, 2'b00, 16'h0000);
        step();
        chk_cyc("hold_done", 4'b1100, 2'b00, 16'h0000);
        step();
        chk_cyc("hold_idle", 4'b0000, 2'b00, 16'h0000);
        step();
        start = 1'b0;
        chk_cyc("hold_clear2", 4'b1010, 2'b00, 16'h0000);
        step();
        chk_cyc("hold_done2", 4'b1100, 2'b00, 16'h0000);
        step();
        chk_cyc("hold_idle2", 4'b0000, 2'b00, 16'h0000);

        // K=255: 257 FEED cycles, lane1 ends at index 254.
        start = 1'b1;
        k_len = 8'd255;
        step();
        start = 1'b0;
        chk_cyc("k255_clear", 4'b1010, 2'b00, 16'h0000);
        step();
        for (int i = 0; i < 257; i++) begin
            if (i == 0)
                chk_cyc("k255_t0", 4'b1001, 2'b01, 16'h0000);
            else if (i == 254)
                chk_cyc("k255_t254", 4'b1001, 2'b11, 16'hFDFE);
            else if (i == 255)
                chk_cyc("k255_t255", 4'b1001, 2'b10, 16'hFE00);
            else if (i == 256)
                chk_cyc("k255_t256", 4'b1001, 2'b00, 16'h0000);
            else
                chk($sformatf("k255_en_t%0d", i), {28'd0, busy, done, clear, en}, 32'h9);
            step();
        end
        chk_cyc("k255_drain", 4'b1001, 2'b00, 16'h0000);
        step();
        chk_cyc("k255_done", 4'b1100, 2'b00, 16'h0000);
        step();
        chk_cyc("k255_idle", 4'b0000, 2'b00, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
